// File: rtl/riscv_m_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package riscv_m_pkg;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  // Widest operand the helper below can describe.
  localparam int unsigned MaxDataW = 64;

  // Most negative two's-complement value for a w-bit operand (w <= MaxDataW).
  function automatic logic [MaxDataW-1:0] min_signed(input int unsigned w);
    return MaxDataW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared iterative datapath: radix-2 shift-add multiply and restoring divide on unsigned
// magnitudes, one bit per step, using a single 2*DATA_W accumulator.
//   multiply: acc = {partial_hi, multiplier}   -> product after DATA_W steps
//   divide:   acc = {remainder, dividend/quot} -> {remainder, quotient} after DATA_W steps
module muldiv_iter_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_last,
  output logic [2*DATA_W-1:0]   o_acc
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0]   r_b;
  logic                r_is_div;
  logic [CntW-1:0]     r_cnt;

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W-1:0]   w_diff;
  logic                w_ge;

  // One iteration of either algorithm.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    w_ge       = w_rem_sh >= {1'b0, r_b};
    // Only used when w_ge holds, so the true difference fits in DATA_W bits.
    w_diff     = w_rem_sh[DATA_W-1:0] - r_b;
    if (r_is_div) begin
      w_acc_next = {(w_ge ? w_diff : w_rem_sh[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge};
    end else begin
      w_acc_next = {w_sum, r_acc[DATA_W-1:1]};
    end
  end

  // Accumulator, divisor/multiplicand and iteration counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= {{DATA_W{1'b0}}, i_a};
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + CntW'(1);
    end
  end

  assign o_last = (r_cnt == CntW'(DATA_W - 1));
  assign o_acc  = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: control FSM, operand capture, divide special cases and
// final sign correction around the shared iterative core.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter bit          FAST_MUL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_kill,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam logic [DATA_W-1:0] MinNeg = DATA_W'(min_signed(DATA_W));

  state_e              r_state, w_state_next;
  op_e                 r_op, w_op;
  logic                r_is_div;
  logic [DATA_W-1:0]   r_op_a, r_abs_a, r_abs_b, r_result;
  logic                r_neg_q, r_neg_r, r_div_zero, r_div_ovf;
  logic [2*DATA_W-1:0] r_prod;

  logic                w_a_signed, w_b_signed, w_neg_a, w_neg_b;
  logic                w_div_zero, w_div_ovf, w_accept, w_fast_op;
  logic                w_core_step, w_core_last;
  logic [DATA_W-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_fix_result;
  logic [2*DATA_W-1:0] w_core_acc, w_mag_prod, w_prod;

  // Decode the incoming request: signedness, magnitudes and divide special cases.
  always_comb begin
    w_op       = op_e'(i_funct3);
    w_a_signed = w_op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    w_b_signed = w_op inside {OpMulh, OpDiv, OpRem};
    w_neg_a    = w_a_signed & i_op_a[DATA_W-1];
    w_neg_b    = w_b_signed & i_op_b[DATA_W-1];
    w_abs_a    = w_neg_a ? -i_op_a : i_op_a;
    w_abs_b    = w_neg_b ? -i_op_b : i_op_b;
    w_div_zero = i_funct3[2] & (i_op_b == '0);
    w_div_ovf  = w_b_signed & i_funct3[2] & (i_op_a == MinNeg) & (i_op_b == '1);
    // A request landing on the done cycle is taken, giving back-to-back issue.
    w_accept   = i_start & ~i_kill & ((r_state == StIdle) | (r_state == StDone));
  end

  assign w_fast_op   = FAST_MUL & ~r_is_div;
  assign w_core_step = (r_state == StCalc);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        w_state_next = StIdle;
        if (w_accept) begin
          // Divide-by-zero and signed overflow need no iterations.
          w_state_next = (w_div_zero | w_div_ovf) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (i_kill) begin
          w_state_next = StIdle;
        end else if (w_fast_op | w_core_last) begin
          w_state_next = StFix;
        end
      end
      StFix: begin
        w_state_next = i_kill ? StIdle : StDone;
      end
    endcase
  end

  // Capture the accepted operation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op       <= OpMul;
      r_is_div   <= 1'b0;
      r_op_a     <= '0;
      r_abs_a    <= '0;
      r_abs_b    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= w_op;
      r_is_div   <= i_funct3[2];
      r_op_a     <= i_op_a;
      r_abs_a    <= w_abs_a;
      r_abs_b    <= w_abs_b;
      r_neg_q    <= w_neg_a ^ w_neg_b;
      r_neg_r    <= w_neg_a;
      r_div_zero <= w_div_zero;
      r_div_ovf  <= w_div_ovf;
    end
  end

  // Single-cycle magnitude product, only present when FAST_MUL is set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prod <= '0;
    end else if (FAST_MUL && (r_state == StCalc)) begin
      r_prod <= {{DATA_W{1'b0}}, r_abs_a} * {{DATA_W{1'b0}}, r_abs_b};
    end
  end

  muldiv_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_accept),
    .i_step   (w_core_step),
    .i_is_div (i_funct3[2]),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_last   (w_core_last),
    .o_acc    (w_core_acc)
  );

  // Sign correction and selection of the architectural result.
  always_comb begin
    w_mag_prod   = FAST_MUL ? r_prod : w_core_acc;
    w_prod       = r_neg_q ? -w_mag_prod : w_mag_prod;
    w_quot       = r_neg_q ? -w_core_acc[DATA_W-1:0] : w_core_acc[DATA_W-1:0];
    w_rem        = r_neg_r ? -w_core_acc[2*DATA_W-1:DATA_W] : w_core_acc[2*DATA_W-1:DATA_W];
    w_fix_result = '0;
    unique case (r_op)
      OpMul:                     w_fix_result = w_prod[DATA_W-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_fix_result = w_prod[2*DATA_W-1:DATA_W];
      OpDiv, OpDivu: begin
        if (r_div_zero)     w_fix_result = '1;
        else if (r_div_ovf) w_fix_result = r_op_a;
        else                w_fix_result = w_quot;
      end
      OpRem, OpRemu: begin
        if (r_div_zero)     w_fix_result = r_op_a;
        else if (r_div_ovf) w_fix_result = '0;
        else                w_fix_result = w_rem;
      end
    endcase
  end

  // Result only changes when entering DONE, so a kill leaves the old value visible.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= '0;
    end else if ((r_state == StFix) && !i_kill) begin
      r_result <= w_fix_result;
    end
  end

  assign o_busy   = (r_state == StCalc) | (r_state == StFix);
  assign o_done   = (r_state == StDone);
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: one fast-multiply and one iterative
// instance share operand inputs but have separate start strobes.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start_f, start_s, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] result_f, result_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_W(32), .FAST_MUL(1'b1)) u_fast (
    .i_clk(clk), .i_reset(reset), .i_start(start_f), .i_funct3(funct3), .i_op_a(op_a),
    .i_op_b(op_b), .i_kill(kill), .o_busy(busy_f), .o_done(done_f), .o_result(result_f)
  );

  muldiv_unit #(.DATA_W(32), .FAST_MUL(1'b0)) u_slow (
    .i_clk(clk), .i_reset(reset), .i_start(start_s), .i_funct3(funct3), .i_op_a(op_a),
    .i_op_b(op_b), .i_kill(kill), .o_busy(busy_s), .o_done(done_s), .o_result(result_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and check latency, busy length and result.
  // Returns in the done cycle, so a following call exercises back-to-back issue.
  task automatic run_op(input bit slow, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int n;
    int nbusy;
    bit seen;
    n = 0;
    nbusy = 0;
    seen = 1'b0;
    funct3 = f3;
    op_a = a;
    op_b = b;
    if (slow) start_s = 1'b1;
    else      start_f = 1'b1;
    while (!seen && n < 100) begin
      step();
      start_s = 1'b0;
      start_f = 1'b0;
      n++;
      if (slow ? done_s : done_f) seen = 1'b1;
      else if (slow ? busy_s : busy_f) nbusy++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, nbusy, exp_lat - 1);
    check({tag, "_busy_at_done"}, {31'b0, (slow ? busy_s : busy_f)}, 32'd0);
    check({tag, "_res"}, slow ? result_s : result_f, exp_res);
  endtask

  initial begin
    int ndone;
    int done_at;
    reset = 1'b1; start_f = 1'b0; start_s = 1'b0; kill = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0;
    step();
    step();
    check("rst_busy_f", {31'b0, busy_f}, 32'd0);
    check("rst_done_f", {31'b0, done_f}, 32'd0);
    check("rst_res_f", result_f, 32'd0);
    check("rst_busy_s", {31'b0, busy_s}, 32'd0);
    check("rst_done_s", {31'b0, done_s}, 32'd0);
    check("rst_res_s", result_s, 32'd0);
    reset = 1'b0;
    step();

    // Multiplies
    run_op(1'b0, F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 3,  "mul_fast");
    run_op(1'b1, F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_slow");
    run_op(1'b0, F_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3,  "mulh_fast");
    run_op(1'b0, F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3,  "mulhsu_fast");
    run_op(1'b0, F_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 3,  "mulhu_fast");
    run_op(1'b1, F_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_slow");
    run_op(1'b1, F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "mulhsu_slow");

    // Divides
    run_op(1'b0, F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_neg");
    run_op(1'b0, F_DIVU, 32'd7,         32'd2,         32'd3,         34, "divu");
    run_op(1'b0, F_REMU, 32'd7,         32'd2,         32'd1,         34, "remu");
    run_op(1'b0, F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_negb");
    run_op(1'b0, F_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34, "rem_negb");
    run_op(1'b1, F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_slow");

    // Special cases skip the iterations
    run_op(1'b0, F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 2, "div_by0");
    run_op(1'b0, F_REMU, 32'd5,         32'd0,         32'd5,         2, "remu_by0");
    run_op(1'b0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
    run_op(1'b0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, "rem_ovf");
    run_op(1'b0, F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, "divu_by0");
    run_op(1'b0, F_REM,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 2, "rem_by0");
    step();
    step();

    // Kill in flight: start DIVU in cycle T, kill during T+10
    funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7; start_f = 1'b1;
    step();
    start_f = 1'b0;
    ndone = 0;
    for (int i = 1; i < 10; i++) begin
      step();
      if (done_f) ndone++;
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    if (done_f) ndone++;
    check("kill_busy", {31'b0, busy_f}, 32'd0);
    check("kill_no_done", ndone, 32'd0);
    check("kill_res_kept", result_f, 32'hFFFF_FFF7);
    run_op(1'b0, F_DIVU, 32'd100, 32'd7, 32'd14, 34, "kill_restart");
    step();
    step();

    // Start while busy is dropped: one done for one accepted op
    funct3 = F_MUL; op_a = 32'd3; op_b = 32'd5; start_f = 1'b1;
    step();
    op_a = 32'd2; op_b = 32'd2; start_f = 1'b1;
    step();
    start_f = 1'b0;
    ndone = 0;
    done_at = 0;
    for (int i = 3; i <= 9; i++) begin
      step();
      if (done_f) begin
        ndone++;
        done_at = i;
      end
    end
    check("busy_ign_ndone", ndone, 32'd1);
    check("busy_ign_at", done_at, 32'd3);
    check("busy_ign_res", result_f, 32'd15);

    // Reset in the middle of a divide
    funct3 = F_DIV; op_a = 32'hFFFF_FF9C; op_b = 32'd7; start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", {31'b0, busy_s}, 32'd0);
    check("mid_rst_done", {31'b0, done_s}, 32'd0);
    check("mid_rst_res", result_s, 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_s) ndone++;
    end
    check("mid_rst_no_done", ndone, 32'd0);
    run_op(1'b1, F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "post_rst_div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit adding RV32M execution to the core datapath. It is parametrised in operand width and multiplier implementation. It sits beside the ALU in the execute stage. Datapath asserts start with operands and funct3, stalls the pipeline while busy=1, and captures result on the single-cycle done pulse.

Parameters:
DATA_W, 32, operand/result width (even, >=8)
FAST_MUL, 1, 1 = single-cycle array multiply (registered); 0 = radix-2 shift-add, DATA_W iterations

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request; accepted only when busy=0
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_W  rs1 value
op_b  input  DATA_W  rs2 value
kill  input  1  pipeline flush; aborts any operation in flight
busy  output  1  operation in progress; datapath stalls
done  output  1  one-cycle pulse, result valid
result  output  DATA_W  result; held until next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0. Reset mid-operation discards it; no done is produced.
- FSM states:
  - IDLE: on start & ~kill, latch funct3/op_a/op_b and go to CALC. busy=1 from the next cycle.
  - CALC: FAST_MUL mul takes 1 cycle. Shift-add mul or restoring divide takes DATA_W cycles on absolute values.
  - FIX: apply sign correction and select high/low or quotient/remainder.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start accepted in cycle T gives done in cycle T+L. FAST_MUL=1 mul: L=3. Iterative mul or div: L=DATA_W+2. Special cases: L=2 (skip CALC).
- start while busy=1 is ignored and does not queue.
- start in the same cycle as done is accepted, so back-to-back operations are legal.
- Signedness: MULH treats both operands as signed, MULHSU treats a as signed and b as unsigned, MULHU treats both as unsigned. DIV/REM are signed; DIVU/REMU are unsigned.
- Products are computed at 2*DATA_W bits. MUL returns the low half; MULH* return the high half.
- Division rounds toward zero. Remainder sign equals dividend sign.
- Divide by zero: quotient = all ones (DIV and DIVU), remainder = op_a.
- Signed overflow (op_a = min negative, op_b = -1): DIV returns op_a, REM returns 0.
- Both special cases are decoded in IDLE and go directly to FIX.
- kill: in any non-IDLE state, go to IDLE next cycle with busy=0, no done, and result unchanged. kill & start together in IDLE: start is ignored. kill in the DONE cycle has no effect, because done is already committed.
- result updates only on entry to DONE.

Decomposition:
- Package riscv_m_pkg:
  - enum for the eight funct3 op codes
  - FSM state typedef (IDLE, CALC, FIX, DONE)
  - helper constant for the minimum signed value as a function of DATA_W
- One sub-module, muldiv_iter_core: shared shift/subtract datapath, i.e. the 2*DATA_W accumulator plus iteration counter.
- Top-level muldiv_unit holds the FSM, operand latching, special-case detection and sign fix.

Test Plan:
1. MUL, a=7, b=-3, FAST_MUL=1 -> done at T+3, result=0xFFFFFFEB. With FAST_MUL=0 -> done at T+34, same result.
2. MULH/MULHSU/MULHU, a=0x80000000, b=0xFFFFFFFF -> results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
3. DIV/REM, a=-7, b=2 -> -3 and -1. DIVU a=7, b=2 -> 3. All done at T+34, busy high for exactly 33 cycles.
4. Special cases -> each done at T+2:
   - DIV a=5, b=0 -> 0xFFFFFFFF
   - REMU a=5, b=0 -> 5
   - DIV a=0x80000000, b=-1 -> 0x80000000
   - REM of the same operands -> 0
5. start DIVU, kill at T+10 -> busy=0 at T+11, no done pulse, result unchanged. A new start at T+11 completes normally.
6. Back-to-back: start issued in the done cycle of a previous MUL is accepted. A start pulsed while busy is ignored (exactly one done per accepted start). reset asserted mid-divide -> all outputs 0 the next cycle.
